// File: rtl/mdio_controller.sv
// MDIO management-frame controller.
// Serialises a 32-bit management frame onto MDIO_OUT, MSB first, with MDC running at CLK/2.
// A write (op 01) drives all 32 bits. A read (op 10) drives bits 31:16, then releases the line
// and shifts 16 bits in from MDIO_IN.
// Optional build macro: MDIO_PREAMBLE_EN. When defined, 32 preamble ones are sent before each frame.
module mdio_controller (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MDIO_START,
  input  logic [31:0] T_DATA,
  input  logic        MDIO_IN,
  output logic        MDC,
  output logic        MDIO_OE,
  output logic        MDIO_OUT,
  output logic [15:0] RD_DATA,
  output logic        DATA_RDY,
  output logic        BUSY
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
`ifdef MDIO_PREAMBLE_EN
    ST_PRE  = 3'd1,
`endif
    ST_SEND = 3'd2,
    ST_RECV = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t      state_q;
  logic        mdc_q;
  logic        mdc_d;
  logic        oe_q;
  logic        out_q;
  logic [15:0] rd_data_q;
  logic        rdy_q;
  logic        busy_q;
  logic [31:0] shadow_q;
  logic [15:0] shift_q;
  logic [5:0]  cnt_q;
  logic        tail_q;

  logic        mdc_fall_s;
  logic        mdc_rise_s;
  logic        op_valid_s;
  logic        is_read_s;
  logic [5:0]  stop_idx_s;

  // MDC is about to fall on this edge when it is currently high, and about to rise when it is low.
  assign mdc_fall_s = mdc_q;
  assign mdc_rise_s = ~mdc_q;
  assign mdc_d      = ~mdc_q;
  assign op_valid_s = (T_DATA[29:28] == 2'b01) || (T_DATA[29:28] == 2'b10);
  assign is_read_s  = (shadow_q[29:28] == 2'b10);
  // A read stops driving after bit 16. A write drives down to bit 0.
  assign stop_idx_s = is_read_s ? 6'd16 : 6'd0;

  // Management clock: toggles on every CLK edge while out of reset.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      mdc_q <= 1'b0;
    end else begin
      mdc_q <= mdc_d;
    end
  end

  // Frame sequencer. Driven bits change on MDC falls and read data is sampled on MDC rises.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= ST_IDLE;
      oe_q      <= 1'b0;
      out_q     <= 1'b0;
      rd_data_q <= 16'h0000;
      rdy_q     <= 1'b0;
      busy_q    <= 1'b0;
      shadow_q  <= 32'h0000_0000;
      shift_q   <= 16'h0000;
      cnt_q     <= 6'd0;
      tail_q    <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (MDIO_START && op_valid_s) begin
            shadow_q <= T_DATA;
            busy_q   <= 1'b1;
            tail_q   <= 1'b0;
            cnt_q    <= 6'd31;
`ifdef MDIO_PREAMBLE_EN
            state_q  <= ST_PRE;
`else
            state_q  <= ST_SEND;
`endif
          end
        end
`ifdef MDIO_PREAMBLE_EN
        ST_PRE: begin
          if (mdc_fall_s) begin
            oe_q  <= 1'b1;
            out_q <= 1'b1;
            if (cnt_q == 6'd0) begin
              state_q <= ST_SEND;
              cnt_q   <= 6'd31;
            end else begin
              cnt_q <= cnt_q - 6'd1;
            end
          end
        end
`endif
        ST_SEND: begin
          if (mdc_fall_s) begin
            if (tail_q) begin
              // The last driven bit has now been held for a full MDC period, so release the line.
              oe_q   <= 1'b0;
              out_q  <= 1'b0;
              tail_q <= 1'b0;
              if (is_read_s) begin
                state_q <= ST_RECV;
                cnt_q   <= 6'd15;
              end else begin
                state_q <= ST_DONE;
                cnt_q   <= 6'd0;
              end
            end else begin
              oe_q  <= 1'b1;
              out_q <= shadow_q[cnt_q[4:0]];
              if (cnt_q == stop_idx_s) begin
                tail_q <= 1'b1;
              end else begin
                cnt_q <= cnt_q - 6'd1;
              end
            end
          end
        end
        ST_RECV: begin
          if (mdc_rise_s) begin
            shift_q <= {shift_q[14:0], MDIO_IN};
            if (cnt_q == 6'd0) begin
              rd_data_q <= {shift_q[14:0], MDIO_IN};
              rdy_q     <= 1'b1;
              state_q   <= ST_DONE;
              // DONE is entered mid-period here, so one extra MDC fall is skipped to keep the receive window at 16 periods.
              cnt_q     <= 6'd1;
            end else begin
              cnt_q <= cnt_q - 6'd1;
            end
          end
        end
        ST_DONE: begin
          if (mdc_fall_s) begin
            oe_q  <= 1'b0;
            out_q <= 1'b0;
            if (cnt_q == 6'd0) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              cnt_q <= cnt_q - 6'd1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          oe_q    <= 1'b0;
          out_q   <= 1'b0;
        end
      endcase
    end
  end

  assign MDC      = mdc_q;
  assign MDIO_OE  = oe_q;
  assign MDIO_OUT = out_q;
  assign RD_DATA  = rd_data_q;
  assign DATA_RDY = rdy_q;
  assign BUSY     = busy_q;

endmodule
